// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Purpose  : Bit-serial WIDTH-bit adder, LSB first, start/busy/done handshake.
//             Define SERIAL_SUB_EN to add the sub port (two's-complement a-b).
//  Revision : 1.0  initial release
// ============================================================================
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int               CNT_W  = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic             sub_mode;
  logic             start_sub;
  logic             b_eff;
  logic             sum_bit;
  logic             carry_nxt;

`ifdef SERIAL_SUB_EN
  logic sub_q, sub_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= 1'b0;
    end else begin
      sub_q <= sub_d;
    end
  end

  always_comb begin
    sub_d = sub_q;
    if (state_q == IDLE && start) begin
      sub_d = sub;
    end
  end

  assign sub_mode  = sub_q;
  assign start_sub = sub;
`else
  assign sub_mode  = 1'b0;
  assign start_sub = 1'b0;
`endif

  // Subtract inverts B and seeds the carry with 1 at launch.
  assign b_eff     = b_sr_q[0] ^ sub_mode;
  assign sum_bit   = a_sr_q[0] ^ b_eff ^ carry_q;
  assign carry_nxt = (a_sr_q[0] & b_eff) | (a_sr_q[0] & carry_q) | (b_eff & carry_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ADD;
          a_sr_d  = a;
          b_sr_d  = b;
          cnt_d   = '0;
          carry_d = start_sub;
        end
      end
      ADD: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        sum_d   = {sum_bit, sum_q[WIDTH-1:1]};
        carry_d = carry_nxt;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == C_LAST) begin
          state_d = DONE;
          cout_d  = carry_nxt;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q == ADD) || (state_q == DONE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder
//  Purpose  : Self-checking bench for serial_adder (WIDTH=8), table vectors
//             plus scoreboard; exercises SERIAL_SUB_EN vectors when defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_adder;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
`ifdef SERIAL_SUB_EN
  logic         sub_r;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int           n_vec = 0;
  int           n_err = 0;
  logic [W:0]   exp_q[$];
  vec_t         tbl[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_SUB_EN
    .sub   (sub_r),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        chk("sum", 32'(sum), 32'(e[W-1:0]));
        chk("cout", 32'(cout), 32'(e[W]));
      end
    end
  end

  task automatic drive_start(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub);
    start = 1'b1;
    a     = ia;
    b     = ib;
`ifdef SERIAL_SUB_EN
    sub_r = isub;
`else
    if (isub) $display("note: sub vector ignored in add-only build");
`endif
  endtask

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic isub, input logic [W:0] expv);
    int n;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    drive_start(ia, ib, isub);
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    n = 0; busy_cnt = 0; seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (busy) busy_cnt++;
      if (done) seen = 1;
    end
    chk("done_latency", 32'(n), 32'(W + 1));
    chk("busy_cycles", 32'(busy_cnt), 32'(W + 1));
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    int cyc;
    int last_cyc;
    logic [W-1:0] ra, rb;

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
`ifdef SERIAL_SUB_EN
    sub_r = 1'b0;
`endif
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    tbl.push_back('{a: 8'h0F, b: 8'h01, sub: 1'b0, s: 8'h10, co: 1'b0});
    tbl.push_back('{a: 8'hFF, b: 8'h01, sub: 1'b0, s: 8'h00, co: 1'b1});
    tbl.push_back('{a: 8'hAA, b: 8'h55, sub: 1'b0, s: 8'hFF, co: 1'b0});
    tbl.push_back('{a: 8'h00, b: 8'h00, sub: 1'b0, s: 8'h00, co: 1'b0});
    tbl.push_back('{a: 8'hFF, b: 8'hFF, sub: 1'b0, s: 8'hFE, co: 1'b1});
`ifdef SERIAL_SUB_EN
    tbl.push_back('{a: 8'h05, b: 8'h07, sub: 1'b1, s: 8'hFE, co: 1'b0});
    tbl.push_back('{a: 8'h07, b: 8'h05, sub: 1'b1, s: 8'h02, co: 1'b1});
    tbl.push_back('{a: 8'h33, b: 8'h33, sub: 1'b1, s: 8'h00, co: 1'b1});
`endif
    for (int i = 0; i < 6; i++) begin
      logic [W:0] m;
      logic       sb;
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef SERIAL_SUB_EN
      sb = 1'($urandom);
`else
      sb = 1'b0;
`endif
      if (sb) m = {1'b0, ra} + {1'b0, ~rb} + 9'd1;
      else    m = {1'b0, ra} + {1'b0, rb};
      tbl.push_back('{a: ra, b: rb, sub: sb, s: m[W-1:0], co: m[W]});
    end

    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].sub, {tbl[i].co, tbl[i].s});
    end

    // Start pulse mid-operation with different operands must be ignored.
    @(negedge clk);
    drive_start(8'h12, 8'h34, 1'b0);
    exp_q.push_back({1'b0, 8'h46});
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    drive_start(8'hFF, 8'hFF, 1'b0);
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("ignored_start_dones", 32'(ndone), 32'd1);

    // Asynchronous reset abort mid-ADD: no done pulse may follow.
    @(negedge clk);
    drive_start(8'hFF, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h03, 8'h04, 1'b0, {1'b0, 8'h07});

    // Start held high: back-to-back operations every WIDTH+2 cycles.
    @(negedge clk);
    drive_start(8'h80, 8'h80, 1'b0);
    repeat (3) exp_q.push_back({1'b1, 8'h00});
    ndone = 0; cyc = 0; last_cyc = 0;
    while (ndone < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        if (ndone > 0) chk("b2b_period", 32'(cyc - last_cyc), 32'(W + 2));
        last_cyc = cyc;
        ndone++;
        if (ndone == 3) start = 1'b0;
      end
    end
    chk("b2b_count", 32'(ndone), 32'd3);
    repeat (4) @(negedge clk);
    chk("b2b_idle", 32'(busy), 32'd0);

    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
